// File: rtl/pipe_stage_skid_pkg.sv
// pipe_pkg: types and constants shared by the pipeline-stage registers.
//   pipe_state_t : stage fill state (EMPTY / FULL / SKID)
//   RV_NOP       : addi x0,x0,0, used to build BUBBLE_VALUE for
//                  stages that carry an instruction word
//   occ_of()     : occupancy count for a given fill state
package pipe_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      PS_FULL: occ_of = 2'd1;
      PS_SKID: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: handshake bundle around one pipeline stage.
//   flush                  hazard-unit flush (sync)
//   in_valid/in_data       upstream payload, in_ready back to upstream
//   out_valid/out_data     payload to downstream, out_ready from downstream
//   occupancy              entries held by the stage (0..2)
// master = the environment (upstream + downstream + hazard unit),
// slave  = the stage itself.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 96
);
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with optional 2-entry skid.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : pipe_stage_skid_if.slave (flush, in_*, out_*, occupancy)
// SKID_EN=1: in_ready is a flop, so a downstream stall never reaches
//            upstream combinationally; a payload arriving during the stall
//            edge is parked in the skid register.
// SKID_EN=0: single register, in_ready = !out_valid | out_ready.
// out_data shows BUBBLE_VALUE whenever out_valid is low.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W       = 96,
  parameter bit                SKID_EN      = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VALUE = '0
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_skid_if.slave bus
);

  pipe_state_t       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, w_main_nxt;
  logic [DATA_W-1:0] w_skid, w_skid_nxt;
  logic              r_out_valid;
  logic [1:0]        r_occ;
  logic              w_in_ready;
  logic              w_in_xfer;

  assign w_in_xfer = bus.in_valid & w_in_ready;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= PS_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // next-state logic; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = PS_EMPTY;
    end else begin
      case (r_state)
        PS_EMPTY: if (w_in_xfer) w_state_nxt = PS_FULL;
        PS_FULL: begin
          // without a skid, in_ready is low in a stalled FULL, so the
          // first branch can only fire when SKID_EN=1
          if (w_in_xfer && !bus.out_ready && SKID_EN) w_state_nxt = PS_SKID;
          else if (!w_in_xfer && bus.out_ready)       w_state_nxt = PS_EMPTY;
        end
        PS_SKID:  if (bus.out_ready) w_state_nxt = PS_FULL;
        default:  w_state_nxt = PS_EMPTY;
      endcase
    end
  end

  // datapath next values
  always_comb begin
    w_main_nxt = r_main;
    w_skid_nxt = w_skid;
    if (bus.flush) begin
      w_main_nxt = BUBBLE_VALUE;
      w_skid_nxt = BUBBLE_VALUE;
    end else begin
      case (r_state)
        PS_EMPTY: if (w_in_xfer) w_main_nxt = bus.in_data;
        PS_FULL: begin
          if (w_in_xfer && bus.out_ready) w_main_nxt = bus.in_data;
          else if (w_in_xfer)             w_skid_nxt = bus.in_data;
          else if (bus.out_ready)         w_main_nxt = BUBBLE_VALUE;
        end
        PS_SKID: begin
          if (bus.out_ready) begin
            w_main_nxt = w_skid;
            w_skid_nxt = BUBBLE_VALUE;
          end
        end
        default: w_main_nxt = BUBBLE_VALUE;
      endcase
    end
  end

  // outputs are registered from the next state so they are glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main      <= BUBBLE_VALUE;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_main      <= w_main_nxt;
      r_out_valid <= (w_state_nxt != PS_EMPTY);
      r_occ       <= occ_of(w_state_nxt);
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] r_skid;
      logic              r_in_ready;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_skid     <= '0;
          r_in_ready <= 1'b1;
        end else begin
          r_skid     <= w_skid_nxt;
          r_in_ready <= (w_state_nxt != PS_SKID);
        end
      end

      assign w_skid     = r_skid;
      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      logic unused_skid;

      assign w_skid      = '0;
      assign unused_skid = ^w_skid_nxt;
      // legacy stall: accept when empty or when the held payload leaves
      assign w_in_ready  = !r_out_valid | bus.out_ready;
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;
  assign bus.occupancy = r_occ;

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, and bubble insertion. It replaces fixed-width, stall/flush-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined RISC-V core. The hazard unit drives `flush` and back-pressure (`out_ready` low = stall). With `SKID_EN=1`, `in_ready` comes from a register, which removes the combinational stall path from downstream stages to upstream stages.

## Interface
- `DATA_W`, default 96: payload width (e.g. pc + instr + pc_plus4).
- `SKID_EN`, default 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `BUBBLE_VALUE`, default `'0`: `DATA_W`-bit value presented on `out_data` whenever `out_valid=0`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous; discards all held and incoming data.
- `in_valid` in 1: upstream payload valid.
- `in_data` in `DATA_W`: upstream payload.
- `in_ready` out 1: stage can accept a payload this cycle.
- `out_valid` out 1: `out_data` holds a real payload.
- `out_data` out `DATA_W`: registered payload, or `BUBBLE_VALUE` when empty.
- `out_ready` in 1: downstream accepts; 0 = stall.
- `occupancy` out 2: entries held (0, 1, 2).

## Operation
- Transfers:
  - An input transfer occurs when `in_valid & in_ready`.
  - An output transfer occurs when `out_valid & out_ready`.
- Storage:
  - Main register drives `out_data`.
  - Skid register exists only when `SKID_EN=1`.
- States (`SKID_EN=1`):
  - EMPTY: `in_ready=1`, `out_valid=0`.
    - `in_valid` → FULL; main ← `in_data`.
  - FULL: `in_ready=1`, `out_valid=1`.
    - `in_valid & out_ready` → FULL; main ← `in_data`.
    - `!in_valid & out_ready` → EMPTY; main ← `BUBBLE_VALUE`.
    - `in_valid & !out_ready` → SKID; skid ← `in_data`; main holds.
    - Otherwise: hold.
  - SKID: `in_ready=0`, `out_valid=1`.
    - `out_ready` → FULL; main ← skid.
    - Otherwise: hold.
    - `in_valid` is ignored in this state.
- `SKID_EN=0`:
  - Only EMPTY and FULL exist.
  - `in_ready = !out_valid | out_ready` (combinational).
  - A stalled FULL holds main unchanged, matching legacy stall semantics.
- Flush:
  - Highest priority below reset.
  - At the next edge: state → EMPTY, main and skid ← `BUBBLE_VALUE`, `occupancy` → 0.
  - An input transfer in the flush cycle is dropped.
  - An output transfer in the flush cycle still counts for the downstream stage.
- Reset (asynchronous, any time, including mid-transfer or in SKID):
  - state EMPTY, `out_valid=0`, `out_data=BUBBLE_VALUE`, skid `'0`, `occupancy=0`.
  - `in_ready=1` in both modes.
- Ordering: payloads leave in arrival order; no payload is duplicated or lost except by flush or reset.
- `occupancy`: EMPTY=0, FULL=1, SKID=2. Always 0 or 1 when `SKID_EN=0`.

## Timing
- Latency: a payload accepted at edge N is visible on `out_data` with `out_valid=1` after edge N; one cycle.
- Throughput: 1 payload/cycle while `out_ready=1`, in both modes.
- `SKID_EN=1` timing:
  - `in_ready` falls one cycle after the stall that fills the skid.
  - `in_ready` rises one cycle after `out_ready` drains the skid.
  - `in_ready`, `out_valid`, `out_data` and `occupancy` are all flop outputs.
- `SKID_EN=0`: `in_ready` has a combinational path from `out_ready`.
- `out_data` changes only at clock edges or on reset assertion. It is stable while `out_valid & !out_ready`.

## Structure
- Shared package `pipe_pkg`:
  - `typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_t`.
  - Constant `RV_NOP = 32'h0000_0013`, for building `BUBBLE_VALUE` in instruction-carrying stages.
- One module, no sub-module. A `generate` on `SKID_EN` selects the skid register and the `in_ready` logic.

## Test plan
- Reset mid-SKID (`DATA_W=32`): fill with `0xA1`, `0xA2` under stall, assert `reset` between edges → `out_valid=0`, `out_data=BUBBLE_VALUE`, `in_ready=1`, `occupancy=0` immediately.
- Streaming: push `0x10..0x1F` with `out_ready=1` → each appears one cycle later, 16 consecutive `out_valid` cycles, `occupancy` stays 1.
- Stall into skid (`SKID_EN=1`): push `0x20`, `0x21` with `out_ready=0` → `out_data=0x20`, `occupancy=2`, `in_ready=0`. Raise `out_ready` → `0x20` then `0x21` delivered in order, no `0x22` accepted until `in_ready` is 1.
- Flush with simultaneous input: FULL with `0x30`, assert `flush` with `in_valid=1` and `in_data=0x31` → next cycle `out_valid=0`, `out_data=BUBBLE_VALUE`, and `0x31` never appears.
- `SKID_EN=0` legacy stall: hold `out_ready=0` for 3 cycles with `0x40` held → `out_data=0x40` held, `in_ready=0` combinationally, `occupancy` never exceeds 1.
- Random scoreboard, 10k cycles: random `in_valid`, `out_ready` and `flush` → output sequence equals input sequence minus flushed entries, and `out_valid & !out_ready` never changes `out_data`.
